// File: rtl/pagerank_pkg.sv
// Shared types and fixed-point constants for the pagerank gather stage.
package pagerank_pkg;

    localparam int FIXED_W        = 64;
    localparam int FRAC_BITS      = 32;
    localparam int NODES_IN_GRAPH = 32;
    localparam int ID_W           = 32;
    localparam int CNT_W          = 32;
    localparam int IDX_W          = $clog2(NODES_IN_GRAPH);

    // d = 0.85 and (1-d)/N, both in unsigned Q32.32
    localparam logic [FIXED_W-1:0] DAMPING = 64'd3650722202;
    localparam logic [FIXED_W-1:0] BASE    = 64'd20132659;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        APPLY = 2'd2,
        DONE  = 2'd3
    } gather_state_t;

endpackage

// File: rtl/pagerank_damp_mac.sv
// Combinational damping stage: rank = BASE + (DAMPING * acc) >> FRAC_BITS.
// The product is kept at 96 bits, which is exactly enough to hold the
// Q32.32 integer and fraction bits that survive the shift.
module pagerank_damp_mac
    import pagerank_pkg::*;
#(
    parameter logic [FIXED_W-1:0] DAMP_P = DAMPING,
    parameter logic [FIXED_W-1:0] BASE_P = BASE
) (
    input  logic [FIXED_W-1:0] acc_i,
    output logic [FIXED_W-1:0] rank_o
);

    localparam int PROD_W = FIXED_W + FRAC_BITS;

    logic [PROD_W-1:0] prod_s;

    // Multiply, drop the fraction bits of the product, add the base term (wraps at 64 bits)
    always_comb begin
        prod_s = {{FRAC_BITS{1'b0}}, acc_i} * {{FRAC_BITS{1'b0}}, DAMP_P};
        rank_o = BASE_P + FIXED_W'(prod_s >> FRAC_BITS);
    end

endmodule

// File: rtl/pagerank_gather.sv
// Gather end of the pagerank scatter stream: accumulates per-node
// contributions, then streams damped ranks out one node per handshake.
module pagerank_gather
    import pagerank_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start_iteration,
    input  logic               scatter_valid,
    input  logic [ID_W-1:0]    scatter_node_id,
    input  logic [FIXED_W-1:0] scatter_value,
    input  logic               scatter_done,
    output logic               scatter_ready,
    input  logic               rank_ready,
    output logic               rank_valid,
    output logic [ID_W-1:0]    rank_node_id,
    output logic [FIXED_W-1:0] rank_value,
    output logic               iteration_done,
    output logic [CNT_W-1:0]   update_count,
    output logic [CNT_W-1:0]   drop_count
);

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NODES_IN_GRAPH - 1);

    gather_state_t      state_q;
    logic [FIXED_W-1:0] acc_q [NODES_IN_GRAPH];
    logic [FIXED_W-1:0] acc_d [NODES_IN_GRAPH];
    logic [IDX_W-1:0]   k_q;
    logic [IDX_W-1:0]   k_d;
    logic               take_s;
    logic               in_range_s;
    logic [IDX_W-1:0]   idx_s;
    logic [FIXED_W-1:0] mac_in_s;
    logic [FIXED_W-1:0] mac_rank_s;

    logic               scatter_ready_q;
    logic               rank_valid_q;
    logic [ID_W-1:0]    rank_node_id_q;
    logic [FIXED_W-1:0] rank_value_q;
    logic               iteration_done_q;
    logic [CNT_W-1:0]   update_count_q;
    logic [CNT_W-1:0]   drop_count_q;

    // Next-state accumulators and rank index; the MAC reads the next-state
    // value so a registered rank can include a same-cycle update
    always_comb begin
        acc_d      = acc_q;
        k_d        = k_q;
        take_s     = (state_q == ACCUM) && scatter_valid;
        in_range_s = (scatter_node_id < ID_W'(NODES_IN_GRAPH));
        idx_s      = scatter_node_id[IDX_W-1:0];
        case (state_q)
            IDLE: begin
                if (start_iteration) begin
                    for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                        acc_d[i] = {FIXED_W{1'b0}};
                    end
                    k_d = {IDX_W{1'b0}};
                end else begin
                    k_d = k_q;
                end
            end
            ACCUM: begin
                if (take_s && in_range_s) begin
                    acc_d[idx_s] = acc_q[idx_s] + scatter_value;
                end else begin
                    acc_d[idx_s] = acc_q[idx_s];
                end
                k_d = {IDX_W{1'b0}};
            end
            APPLY: begin
                if (rank_ready && (k_q != LAST_K)) begin
                    k_d = k_q + IDX_W'(1);
                end else begin
                    k_d = k_q;
                end
            end
            DONE:    k_d = k_q;
            default: k_d = k_q;
        endcase
        mac_in_s = acc_d[k_d];
    end

    pagerank_damp_mac u_mac (
        .acc_i  (mac_in_s),
        .rank_o (mac_rank_s)
    );

    // Accumulator array and rank index registers
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                acc_q[i] <= {FIXED_W{1'b0}};
            end
            k_q <= {IDX_W{1'b0}};
        end else begin
            acc_q <= acc_d;
            k_q   <= k_d;
        end
    end

    // Control FSM with registered handshake, rank and counter outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            scatter_ready_q  <= 1'b0;
            rank_valid_q     <= 1'b0;
            rank_node_id_q   <= {ID_W{1'b0}};
            rank_value_q     <= {FIXED_W{1'b0}};
            iteration_done_q <= 1'b0;
            update_count_q   <= {CNT_W{1'b0}};
            drop_count_q     <= {CNT_W{1'b0}};
        end else begin
            iteration_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_iteration) begin
                        state_q         <= ACCUM;
                        scatter_ready_q <= 1'b1;
                        update_count_q  <= {CNT_W{1'b0}};
                        drop_count_q    <= {CNT_W{1'b0}};
                    end
                end
                ACCUM: begin
                    if (take_s && in_range_s) begin
                        update_count_q <= update_count_q + 32'd1;
                    end else if (take_s) begin
                        drop_count_q <= drop_count_q + 32'd1;
                    end
                    if (scatter_done) begin
                        state_q         <= APPLY;
                        scatter_ready_q <= 1'b0;
                        rank_valid_q    <= 1'b1;
                        rank_node_id_q  <= {ID_W{1'b0}};
                        rank_value_q    <= mac_rank_s;
                    end
                end
                APPLY: begin
                    if (rank_ready && (k_q == LAST_K)) begin
                        state_q          <= DONE;
                        rank_valid_q     <= 1'b0;
                        rank_node_id_q   <= {ID_W{1'b0}};
                        rank_value_q     <= {FIXED_W{1'b0}};
                        iteration_done_q <= 1'b1;
                    end else if (rank_ready) begin
                        rank_node_id_q <= ID_W'(k_d);
                        rank_value_q   <= mac_rank_s;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign scatter_ready  = scatter_ready_q;
    assign rank_valid     = rank_valid_q;
    assign rank_node_id   = rank_node_id_q;
    assign rank_value     = rank_value_q;
    assign iteration_done = iteration_done_q;
    assign update_count   = update_count_q;
    assign drop_count     = drop_count_q;

endmodule
